// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo_param                                                  |
// | Brief   : Parametrised single-clock FIFO with occupancy, level flags and   |
// |           sticky overflow/underflow; SYNC_FIFO_FWFT_EN selects FWFT read.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo_param #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF_LVL    = CW'(AF_LVL);
  localparam logic [CW-1:0] c_AE_LVL    = CW'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  assign full         = (count_q == c_DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= c_AF_LVL);
  assign almost_empty = (count_q <= c_AE_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = push & ~full;
  assign rd_acc = pop & ~empty;

  // A new error in the same cycle as clr_err must survive the clear.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    overflow_d  = (overflow_q & ~clr_err) | (push & full);
    underflow_d = (underflow_q & ~clr_err) | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset; reset still blocks a concurrent push.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr_q] <= din;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout       = mem[rd_ptr_q];
  assign dout_valid = ~empty;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  always_comb begin
    dout_d       = rd_acc ? mem[rd_ptr_q] : dout_q;
    dout_valid_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sync_fifo_param                                               |
// | Brief   : Directed self-checking bench for sync_fifo_param (DEPTH=4).      |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, push, pop, clr_err;
  logic [3:0] din;
  logic [3:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  sync_fifo_param #(.DATA_W(4), .DEPTH(4), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic r, input logic p, input logic [3:0] d,
                     input logic o, input logic c);
    rst = r; push = p; din = d; pop = o; clr_err = c;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk_pop(input string tag, input logic [3:0] exp);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_dv"}, 32'(dout_valid), 32'd1);
`else
    chk({tag, "_tag_only"}, 32'(exp), 32'(exp) ^ 32'(dout) ^ 32'(dout));
`endif
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;

    // 1: reset and idle
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_dv", 32'(dout_valid), 0);

    // 2: fill then drain
    cyc(0, 1, 4'h1, 0, 0);
    chk("f1_count", 32'(count), 1);
    chk("f1_empty", 32'(empty), 0);
    chk("f1_ae", 32'(almost_empty), 1);
    cyc(0, 1, 4'h2, 0, 0);
    chk("f2_count", 32'(count), 2);
    chk("f2_ae", 32'(almost_empty), 0);
    chk("f2_af", 32'(almost_full), 0);
    cyc(0, 1, 4'h3, 0, 0);
    chk("f3_count", 32'(count), 3);
    chk("f3_af", 32'(almost_full), 1);
    chk("f3_full", 32'(full), 0);
    cyc(0, 1, 4'h4, 0, 0);
    chk("f4_count", 32'(count), 4);
    chk("f4_full", 32'(full), 1);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_head", 32'(dout), 32'h1);
    chk("fwft_dv", 32'(dout_valid), 1);
`endif
    cyc(0, 0, 0, 1, 0);
    chk_pop("p1", 4'h1);
    chk("p1_count", 32'(count), 3);
    chk("p1_full", 32'(full), 0);
    cyc(0, 0, 0, 1, 0);
    chk_pop("p2", 4'h2);
    cyc(0, 0, 0, 1, 0);
    chk_pop("p3", 4'h3);
    cyc(0, 0, 0, 1, 0);
    chk_pop("p4", 4'h4);
    chk("p4_empty", 32'(empty), 1);
    chk("p4_unf", 32'(underflow), 0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_dv", 32'(dout_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("idle_hold", 32'(dout), 32'h4);
`endif

    // 3: overflow, clear, drain
    cyc(0, 1, 4'h8, 0, 0);
    cyc(0, 1, 4'h9, 0, 0);
    cyc(0, 1, 4'hB, 0, 0);
    cyc(0, 1, 4'hC, 0, 0);
    cyc(0, 1, 4'hA, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(overflow), 0);
    // push+pop when full: pop wins, push dropped
    cyc(0, 1, 4'hA, 1, 0);
    chk_pop("fp", 4'h8);
    chk("fp_count", 32'(count), 3);
    chk("fp_ovf", 32'(overflow), 1);
    cyc(0, 0, 0, 1, 1);
    chk_pop("d2", 4'h9);
    chk("d2_ovf_clr", 32'(overflow), 0);
    cyc(0, 0, 0, 1, 0);
    chk_pop("d3", 4'hB);
    cyc(0, 0, 0, 1, 0);
    chk_pop("d4", 4'hC);
    chk("d4_empty", 32'(empty), 1);
    // error in same cycle as clr_err: set wins
    cyc(0, 0, 0, 1, 1);
    chk("setwins_unf", 32'(underflow), 1);
    chk("setwins_dv", 32'(dout_valid), 0);
    cyc(0, 0, 0, 0, 1);
    chk("unf_clr", 32'(underflow), 0);

    // 4: push+pop from empty
    cyc(0, 1, 4'h5, 1, 0);
    chk("pe_count", 32'(count), 1);
    chk("pe_unf", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("pe_dv", 32'(dout_valid), 0);
`endif
    cyc(0, 0, 0, 1, 1);
    chk_pop("pe_pop", 4'h5);
    chk("pe_empty", 32'(empty), 1);

    // 5: interleaved wrap-around
    cyc(0, 1, 4'h6, 0, 0);
    cyc(0, 1, 4'h7, 1, 0);
    chk_pop("w6", 4'h6);
    chk("w6_count", 32'(count), 1);
    cyc(0, 1, 4'h8, 1, 0);
    chk_pop("w7", 4'h7);
    cyc(0, 1, 4'h9, 1, 0);
    chk_pop("w8", 4'h8);
    cyc(0, 1, 4'hA, 1, 0);
    chk_pop("w9", 4'h9);
    cyc(0, 1, 4'hB, 1, 0);
    chk_pop("wA", 4'hA);
    chk("wA_count", 32'(count), 1);
    cyc(0, 0, 0, 1, 0);
    chk_pop("wB", 4'hB);
    chk("w_empty", 32'(empty), 1);
    chk("w_ovf", 32'(overflow), 0);
    chk("w_unf", 32'(underflow), 0);

    // 6: reset mid-operation wins over push
    cyc(0, 1, 4'h1, 0, 0);
    cyc(0, 1, 4'h2, 0, 0);
    cyc(0, 1, 4'h3, 0, 0);
    chk("pre_rst_count", 32'(count), 3);
    cyc(1, 1, 4'hF, 0, 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_dv", 32'(dout_valid), 0);
    cyc(0, 0, 0, 1, 0);
    chk("mrst_unf", 32'(underflow), 1);
    chk("mrst_pop_dv", 32'(dout_valid), 0);
    cyc(0, 1, 4'h7, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft7_dout", 32'(dout), 32'h7);
    chk("fwft7_dv", 32'(dout_valid), 1);
`else
    chk("std7_dv", 32'(dout_valid), 0);
    cyc(0, 0, 0, 1, 0);
    chk_pop("std7", 4'h7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
